// File: rtl/adder_rr_scheduler.sv
// ============================================================================
// Module   : adder_rr_scheduler (+ pipelined_adder_core)
// Brief    : round-robin sharing of one block-carry pipelined adder among NREQ requesters
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipelined_adder_core #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             v_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             v_out,
  output logic [WIDTH-1:0] sum
);
  localparam int NB = WIDTH / BLOCK;

  // Stage k resolves sum block k; operands ride along so later blocks see them.
  logic             v_q [NB];
  logic             v_d [NB];
  logic             c_q [NB];
  logic             c_d [NB];
  logic [WIDTH-1:0] a_q [NB];
  logic [WIDTH-1:0] a_d [NB];
  logic [WIDTH-1:0] b_q [NB];
  logic [WIDTH-1:0] b_d [NB];
  logic [WIDTH-1:0] s_q [NB];
  logic [WIDTH-1:0] s_d [NB];

  always_comb begin
    logic [BLOCK:0]   blk;
    logic [WIDTH-1:0] a_in, b_in, s_in;
    logic             c_in, vi;
    int               prev;
    blk  = '0;
    a_in = '0;
    b_in = '0;
    s_in = '0;
    c_in = 1'b0;
    vi   = 1'b0;
    prev = 0;
    for (int k = 0; k < NB; k++) begin
      prev = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        a_in = a;
        b_in = b;
        s_in = '0;
        c_in = cin;
        vi   = v_in;
      end else begin
        a_in = a_q[prev];
        b_in = b_q[prev];
        s_in = s_q[prev];
        c_in = c_q[prev];
        vi   = v_q[prev];
      end
      blk = {1'b0, a_in[k*BLOCK +: BLOCK]} + {1'b0, b_in[k*BLOCK +: BLOCK]}
          + {{BLOCK{1'b0}}, c_in};
      s_d[k] = s_in;
      s_d[k][k*BLOCK +: BLOCK] = blk[BLOCK-1:0];
      c_d[k] = blk[BLOCK];
      v_d[k] = vi;
      a_d[k] = a_in;
      b_d[k] = b_in;
    end
  end

  // Intentionally no reset: the scheduler flushes this pipeline after reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      v_q[k] <= v_d[k];
      c_q[k] <= c_d[k];
      a_q[k] <= a_d[k];
      b_q[k] <= b_d[k];
      s_q[k] <= s_d[k];
    end
  end

  assign v_out = v_q[NB-1];
  assign sum   = s_q[NB-1];
endmodule

module adder_rr_scheduler #(
  parameter int WIDTH   = 32,
  parameter int BLOCK   = 4,
  parameter int NREQ    = 4,
  parameter int LATENCY = WIDTH / BLOCK,
  parameter int ID_W    = $clog2(NREQ),
  parameter int DEPTH   = LATENCY + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic                  resp_valid,
  output logic [ID_W-1:0]       resp_id,
  output logic [WIDTH-1:0]      resp_sum,
  output logic                  busy,
  output logic                  err_orphan
);
  generate
    if (WIDTH % BLOCK != 0) begin : g_bad_block
      $fatal(1, "adder_rr_scheduler: WIDTH must be a multiple of BLOCK");
    end
    if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
      $fatal(1, "adder_rr_scheduler: NREQ must be in 2..16");
    end
  endgenerate

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [0:0] {S_DRAIN = 1'b0, S_RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [ID_W-1:0]   tag_q [DEPTH];
  logic [ID_W-1:0]   tag_d [DEPTH];
  logic              resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;
  logic [WIDTH-1:0]  resp_sum_q, resp_sum_d;
  logic              err_q, err_d;

  logic              accept, pop, core_vout;
  logic [ID_W-1:0]   grant_id;
  logic [WIDTH-1:0]  core_a, core_b, core_sum;
  logic              core_cin;

  // Round-robin scan from rr_q; a full tag FIFO or DRAIN suppresses every grant.
  always_comb begin
    int idx;
    idx       = 0;
    req_ready = '0;
    accept    = 1'b0;
    grant_id  = '0;
    core_a    = '0;
    core_b    = '0;
    core_cin  = 1'b0;
    if (state_q == S_RUN && occ_q != OCC_W'(DEPTH)) begin
      for (int off = 0; off < NREQ; off++) begin
        idx = (int'(rr_q) + off) % NREQ;
        if (!accept && req_valid[idx]) begin
          accept         = 1'b1;
          grant_id       = ID_W'(idx);
          req_ready[idx] = 1'b1;
          core_a         = req_a[idx*WIDTH +: WIDTH];
          core_b         = req_b[idx*WIDTH +: WIDTH];
          core_cin       = req_cin[idx];
        end
      end
    end
  end

  pipelined_adder_core #(.WIDTH(WIDTH), .BLOCK(BLOCK)) u_core (
    .clk   (clk),
    .v_in  (accept),
    .a     (core_a),
    .b     (core_b),
    .cin   (core_cin),
    .v_out (core_vout),
    .sum   (core_sum)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_d         = rr_q;
    occ_d        = occ_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    tag_d        = tag_q;
    resp_id_d    = resp_id_q;
    resp_sum_d   = resp_sum_q;
    err_d        = err_q;
    pop          = 1'b0;
    case (state_q)
      S_DRAIN: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = S_RUN;
      end
      S_RUN: begin
        if (core_vout) begin
          if (occ_q != '0) pop = 1'b1;
          else err_d = 1'b1;
        end
      end
      default: state_d = S_DRAIN;
    endcase
    resp_valid_d = pop;
    if (pop) begin
      resp_id_d  = tag_q[rd_q];
      resp_sum_d = core_sum;
      rd_d       = (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
    end
    if (accept) begin
      tag_d[wr_q] = grant_id;
      wr_d        = (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
      rr_d        = ID_W'((int'(grant_id) + 1) % NREQ);
    end
    if (accept && !pop) occ_d = occ_q + OCC_W'(1);
    else if (!accept && pop) occ_d = occ_q - OCC_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_DRAIN;
      cnt_q        <= CNT_W'(LATENCY);
      rr_q         <= '0;
      occ_q        <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_sum_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_q         <= rr_d;
      occ_q        <= occ_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_sum_q   <= resp_sum_d;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_sum   = resp_sum_q;
  assign err_orphan = err_q;
  assign busy       = (state_q == S_DRAIN) || (occ_q != '0);
endmodule

`default_nettype wire

// File: tb/tb_adder_rr_scheduler.sv
// ============================================================================
// Module   : tb_adder_rr_scheduler
// Brief    : directed + random self-checking bench for adder_rr_scheduler
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_adder_rr_scheduler;
  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int ID_W  = 2;

  logic                  clk, rst;
  logic [NREQ-1:0]       req_valid, req_ready, req_cin;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic                  resp_valid;
  logic [ID_W-1:0]       resp_id;
  logic [WIDTH-1:0]      resp_sum;
  logic                  busy, err_orphan;

  int n_assert = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;

  typedef struct {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] sum;
  } exp_t;
  exp_t sbq[$];

  adder_rr_scheduler #(.WIDTH(32), .BLOCK(4), .NREQ(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .busy       (busy),
    .err_orphan (err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_cin[i]              = c;
  endtask

  // Leaves the caller at the negedge of the response cycle when found.
  task automatic wait_resp(input int max, output bit got);
    got = 1'b0;
    for (int n = 0; n < max && !got; n++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) got = 1'b1;
      else step();
    end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100 && busy !== 1'b0; n++) step();
    check("idle_busy", busy, 0);
  endtask

  function automatic logic [31:0] rr_sum(input int i);
    logic [31:0] a, b;
    a = 32'h1111_1111 * (i + 1);
    b = 32'h0F0F_0F0F + 32'(i);
    return a + b + 32'(i % 2);
  endfunction

  // Scoreboard: responses must come back in global issue order.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
    end else begin
      check("ready_legal", 32'(((req_ready & ~req_valid) == '0) && $onehot0(req_ready)), 1);
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sbq.push_back('{id: ID_W'(i),
                          sum: req_a[i*WIDTH +: WIDTH] + req_b[i*WIDTH +: WIDTH] + 32'(req_cin[i])});
          acc_cnt++;
        end
      end
      if (resp_valid === 1'b1) begin
        check("resp_pending", 32'(sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          exp_t e;
          e = sbq.pop_front();
          check("sb_id", 32'(resp_id), 32'(e.id));
          check("sb_sum", resp_sum, e.sum);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bit got;
    int acc0;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_id", 32'(resp_id), 0);
    check("rst_resp_sum", resp_sum, 0);
    check("rst_err", err_orphan, 0);
    check("rst_busy", busy, 1);

    // Release with everyone requesting: eight drain cycles, then ID0.
    step();
    rst = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(i) * 32'h10, 32'h3, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("drain_ready", 32'(req_ready), 0);
      check("drain_busy", busy, 1);
      step();
    end
    @(negedge clk);
    check("first_grant", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    wait_idle();

    // Single op from requester 2.
    req_valid = 4'b0100;
    set_op(2, 32'hFFFF_FFFF, 32'h0, 1'b1);
    @(negedge clk);
    check("single_ready", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    for (int d = 1; d <= 8; d++) begin
      @(negedge clk);
      check("single_early", resp_valid, 0);
      step();
    end
    @(negedge clk);
    check("single_valid", resp_valid, 1);
    check("single_id", 32'(resp_id), 2);
    check("single_sum", resp_sum, 32'h0000_0000);
    step();
    @(negedge clk);
    check("single_pulse", resp_valid, 0);
    step();

    // Requester 3 once, leaving the pointer at 0.
    req_valid = 4'b1000;
    set_op(3, 32'h0000_0005, 32'h0000_0007, 1'b1);
    @(negedge clk);
    check("r3_ready", 32'(req_ready), 32'b1000);
    step();
    req_valid = '0;
    wait_idle();

    // Round robin with all four requesting.
    for (int i = 0; i < NREQ; i++)
      set_op(i, 32'h1111_1111 * (i + 1), 32'h0F0F_0F0F + 32'(i), 1'(i % 2));
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("rr_grant", 32'(req_ready), 32'(1) << (c % 4));
      step();
    end
    req_valid = '0;
    wait_resp(20, got);
    check("rr_resp_seen", 32'(got), 1);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin
        step();
        @(negedge clk);
      end
      check("rr_resp_valid", resp_valid, 1);
      check("rr_resp_id", 32'(resp_id), 32'(c % 4));
      check("rr_resp_sum", resp_sum, rr_sum(c % 4));
    end
    step();
    @(negedge clk);
    check("rr_resp_end", resp_valid, 0);
    step();

    // Fairness between requesters 1 and 3.
    req_valid = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("fair_grant", 32'(req_ready), (c % 2 == 0) ? 32'b0010 : 32'b1000);
      step();
    end
    req_valid = '0;
    wait_idle();

    // Carry propagation across every block boundary.
    for (int k = 4; k <= 28; k += 4) begin
      set_op(0, 32'((64'd1 << k) - 64'd1), 32'h1, 1'b0);
      req_valid = 4'b0001;
      step();
      req_valid = '0;
      wait_resp(20, got);
      check("carry_seen", 32'(got), 1);
      check("carry_sum", resp_sum, 32'(64'd1 << k));
      step();
    end
    wait_idle();

    // Reset with five ops in flight: none may respond, drain follows.
    for (int i = 0; i < NREQ; i++) set_op(i, 32'hA5A5_0000 + 32'(i), 32'h1, 1'b1);
    req_valid = 4'b1111;
    repeat (5) step();
    req_valid = '0;
    repeat (3) step();
    rst = 1'b1;
    req_valid = 4'b1111;
    @(negedge clk);
    check("mid_rst_ready", 32'(req_ready), 0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("mid_drain_ready", 32'(req_ready), 0);
      check("mid_drain_resp", resp_valid, 0);
      check("mid_drain_busy", busy, 1);
      step();
    end
    req_valid = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("mid_no_resp", resp_valid, 0);
      step();
    end
    check("mid_err", err_orphan, 0);

    // Random traffic.
    acc0 = acc_cnt;
    for (int cyc = 0; cyc < 10000 && (acc_cnt - acc0) < 2000; cyc++) begin
      for (int i = 0; i < NREQ; i++) set_op(i, $urandom, $urandom, 1'($urandom));
      req_valid = 4'($urandom);
      step();
    end
    req_valid = '0;
    check("rand_accepted", 32'(acc_cnt - acc0), 2000);
    wait_idle();
    repeat (2) step();
    @(negedge clk);
    check("rand_sb_empty", 32'(sbq.size()), 0);
    check("rand_busy", busy, 0);
    check("rand_err", err_orphan, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
